dct8_chen_pipe: RTL and testbench



---
 rtl/dct_pkg.sv | 17 +
 rtl/dct_round_sat.sv | 33 +++
 rtl/dct8_chen_pipe.sv | 116 +++++++++++
 tb/tb_dct8_chen_pipe.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Coefficient table and sizing helpers shared by the 8-point Chen DCT pipeline.
package dct_pkg;

   // 0.5*cos(k*pi/16) scaled by 2^16, k = 1..7
   localparam int DCT_K16 [1:7] = '{32139, 30274, 27245, 23170, 18205, 12540, 6393};

   function automatic int dct_coef(input int k, input int frac);
      int ofs;
      ofs = (frac >= 16) ? 0 : (1 << (15 - frac));
      return (DCT_K16[k] + ofs) >>> (16 - frac);
   endfunction

   function automatic int dct_acc_w(input int in_w, input int const_w);
      return in_w + const_w + 4;
   endfunction

endpackage

// File: rtl/dct_round_sat.sv
// Round-half-up rescale of one DCT accumulator to the output width, clipping
// to the signed output range and flagging when a clip happened.
module dct_round_sat #(
   parameter int AW    = 36,
   parameter int FRAC  = 8,
   parameter int OUT_W = 16
) (
   input  logic signed [AW-1:0]    acc_i,
   output logic signed [OUT_W-1:0] data_o,
   output logic                    sat_o
);

   localparam logic signed [AW-1:0] HALF = AW'(1) <<< (FRAC - 1);
   localparam logic signed [AW-1:0] MAXV = (AW'(1) <<< (OUT_W - 1)) - AW'(1);
   localparam logic signed [AW-1:0] MINV = -(AW'(1) <<< (OUT_W - 1));

   logic signed [AW-1:0] r;

   always_comb begin
      r = (acc_i + HALF) >>> FRAC;
      if (r > MAXV) begin
         data_o = MAXV[OUT_W-1:0];
         sat_o  = 1'b1;
      end else if (r < MINV) begin
         data_o = MINV[OUT_W-1:0];
         sat_o  = 1'b1;
      end else begin
         data_o = r[OUT_W-1:0];
         sat_o  = 1'b0;
      end
   end

endmodule

// File: rtl/dct8_chen_pipe.sv
// 8-point forward DCT-II, Chen factorisation: butterfly, multiply/sum and
// round/saturate register stages with a global valid/ready pipeline enable.
module dct8_chen_pipe
   import dct_pkg::*;
#(
   parameter int IN_W    = 16,
   parameter int CONST_W = 16,
   parameter int FRAC    = 8,
   parameter int OUT_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_data [0:7],
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data [0:7],
   output logic [7:0]              out_sat
);

   localparam int AW = dct_acc_w(IN_W, CONST_W);
   localparam int SW = IN_W + 1;
   localparam int EW = IN_W + 2;

   if (FRAC < 1 || FRAC > 16 || CONST_W < FRAC + 1) begin : g_param_check
      $error("dct8_chen_pipe: requires 1 <= FRAC <= 16 and CONST_W >= FRAC+1");
   end

   // Coefficients are quantised to CONST_W first, then widened for the MACs
   localparam logic signed [AW-1:0] K1 = AW'(CONST_W'(dct_coef(1, FRAC)));
   localparam logic signed [AW-1:0] K2 = AW'(CONST_W'(dct_coef(2, FRAC)));
   localparam logic signed [AW-1:0] K3 = AW'(CONST_W'(dct_coef(3, FRAC)));
   localparam logic signed [AW-1:0] K4 = AW'(CONST_W'(dct_coef(4, FRAC)));
   localparam logic signed [AW-1:0] K5 = AW'(CONST_W'(dct_coef(5, FRAC)));
   localparam logic signed [AW-1:0] K6 = AW'(CONST_W'(dct_coef(6, FRAC)));
   localparam logic signed [AW-1:0] K7 = AW'(CONST_W'(dct_coef(7, FRAC)));

   logic                    en;
   logic                    v1_q, v2_q, v3_q;
   logic signed [SW-1:0]    s [4];
   logic signed [SW-1:0]    d_d [4], d_q [4];
   logic signed [EW-1:0]    e_d [4], e_q [4];
   logic signed [AW-1:0]    ew [4], dw [4];
   logic signed [AW-1:0]    acc_d [8], acc_q [8];
   logic signed [OUT_W-1:0] out_data_d [8], out_data_q [8];
   logic [7:0]              out_sat_d, out_sat_q;

   assign en        = !v3_q || out_ready;
   assign in_ready  = en;
   assign out_valid = v3_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

   always_comb begin
      for (int n = 0; n < 4; n++) begin
         s[n]   = SW'(in_data[n]) + SW'(in_data[7-n]);
         d_d[n] = SW'(in_data[n]) - SW'(in_data[7-n]);
      end
      e_d[0] = EW'(s[0]) + EW'(s[3]);
      e_d[1] = EW'(s[1]) + EW'(s[2]);
      e_d[2] = EW'(s[0]) - EW'(s[3]);
      e_d[3] = EW'(s[1]) - EW'(s[2]);
   end

   always_comb begin
      for (int n = 0; n < 4; n++) begin
         ew[n] = AW'(e_q[n]);
         dw[n] = AW'(d_q[n]);
      end
      acc_d[0] = K4 * (ew[0] + ew[1]);
      acc_d[4] = K4 * (ew[0] - ew[1]);
      acc_d[2] = K2 * ew[2] + K6 * ew[3];
      acc_d[6] = K6 * ew[2] - K2 * ew[3];
      acc_d[1] = K1 * dw[0] + K3 * dw[1] + K5 * dw[2] + K7 * dw[3];
      acc_d[3] = K3 * dw[0] - K7 * dw[1] - K1 * dw[2] - K5 * dw[3];
      acc_d[5] = K5 * dw[0] - K1 * dw[1] + K7 * dw[2] + K3 * dw[3];
      acc_d[7] = K7 * dw[0] - K5 * dw[1] + K3 * dw[2] - K1 * dw[3];
   end

   for (genvar k = 0; k < 8; k++) begin : g_rs
      dct_round_sat #(
         .AW    (AW),
         .FRAC  (FRAC),
         .OUT_W (OUT_W)
      ) u_rs (
         .acc_i  (acc_q[k]),
         .data_o (out_data_d[k]),
         .sat_o  (out_sat_d[k])
      );
   end

   // One enable for every stage: a stalled output freezes the whole pipe, bubbles included
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         v3_q       <= 1'b0;
         d_q        <= '{default: '0};
         e_q        <= '{default: '0};
         acc_q      <= '{default: '0};
         out_data_q <= '{default: '0};
         out_sat_q  <= '0;
      end else if (en) begin
         v1_q       <= in_valid;
         v2_q       <= v1_q;
         v3_q       <= v2_q;
         d_q        <= d_d;
         e_q        <= e_d;
         acc_q      <= acc_d;
         out_data_q <= out_data_d;
         out_sat_q  <= out_sat_d;
      end
   end

endmodule

// File: tb/tb_dct8_chen_pipe.sv
// Self-checking bench for dct8_chen_pipe: fixed vectors, streaming, backpressure,
// mid-stream reset and a FRAC sweep against a direct-matrix golden model.
`timescale 1ns/1ps
module tb_dct8_chen_pipe;

   typedef struct packed {
      logic [7:0]       sat;
      logic [7:0][31:0] y;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic in_valid, in_ready, out_valid, out_ready;
   logic signed [15:0] in_data  [0:7];
   logic signed [15:0] out_data [0:7];
   logic [7:0]         out_sat;

   logic               sw_valid;
   logic               sw_ready = 1'b1;
   logic signed [15:0] sw_data [0:7];
   logic               sw_in_rdy [3];
   logic               sw_oval [3];
   logic signed [19:0] sw_out [3][0:7];
   logic [7:0]         sw_sat [3];

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sbq [$];
   exp_t swq [3][$];

   always #5 clk = ~clk;

   dct8_chen_pipe u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   for (genvar g = 0; g < 3; g++) begin : g_sw
      localparam int FR = (g == 0) ? 4 : ((g == 1) ? 12 : 16);
      dct8_chen_pipe #(
         .IN_W    (16),
         .CONST_W (FR + 1),
         .FRAC    (FR),
         .OUT_W   (20)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (sw_valid),
         .in_ready  (sw_in_rdy[g]),
         .in_data   (sw_data),
         .out_valid (sw_oval[g]),
         .out_ready (sw_ready),
         .out_data  (sw_out[g]),
         .out_sat   (sw_sat[g])
      );
   end

   // Golden model: plain 8x8 DCT matrix built from the quantised constants
   function automatic exp_t model(input logic signed [15:0] x [0:7], input int frac, input int out_w);
      longint k16 [9];
      longint kq [9];
      longint acc, r, hi, lo, c;
      int     m;
      exp_t   e;
      k16 = '{0, 32139, 30274, 27245, 23170, 18205, 12540, 6393, 0};
      for (int i = 0; i < 9; i++)
         kq[i] = (k16[i] + ((frac < 16) ? (longint'(1) << (15 - frac)) : longint'(0))) >>> (16 - frac);
      hi = (longint'(1) << (out_w - 1)) - 1;
      lo = -(longint'(1) << (out_w - 1));
      e  = '0;
      for (int kk = 0; kk < 8; kk++) begin
         acc = 0;
         for (int n = 0; n < 8; n++) begin
            if (kk == 0) c = kq[4];
            else begin
               m = (kk * (2 * n + 1)) % 32;
               if (m > 16) m = 32 - m;
               if (m > 8) c = -kq[16 - m];
               else c = kq[m];
            end
            acc += c * longint'(x[n]);
         end
         r = (acc + (longint'(1) << (frac - 1))) >>> frac;
         if (r > hi) begin
            r = hi;
            e.sat[kk] = 1'b1;
         end else if (r < lo) begin
            r = lo;
            e.sat[kk] = 1'b1;
         end
         e.y[kk] = 32'(r);
      end
      return e;
   endfunction

   task automatic rand_vec(output logic signed [15:0] v [0:7]);
      for (int k = 0; k < 8; k++) begin
         case ($urandom_range(0, 7))
            0:       v[k] = 16'sh7FFF;
            1:       v[k] = 16'sh8000;
            default: v[k] = 16'($urandom);
         endcase
      end
   endtask

   task automatic test_reset();
      logic nz;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      n_checks++;
      if (out_sat !== 8'h00) begin n_fail++; $display("FAIL rst_out_sat: got %h want 00", out_sat); end
      nz = 1'b0;
      for (int k = 0; k < 8; k++) if (out_data[k] !== 16'sd0) nz = 1'b1;
      n_checks++;
      if (nz !== 1'b0) begin n_fail++; $display("FAIL rst_out_data: got nonzero=%b want 0", nz); end
      rst = 1'b0;
      sbq.delete();
   endtask

   task automatic test_static_vectors();
      int         cx [4][8];
      int         cy [4][8];
      logic [7:0] cs [4];
      string      nm [4];
      int         lat;
      cx = '{'{256, 0, 0, 0, 0, 0, 0, 0}, '{default: 100}, '{default: 32767}, '{default: -32768}};
      cy = '{'{91, 126, 118, 106, 91, 71, 49, 25}, '{284, 0, 0, 0, 0, 0, 0, 0},
             '{32767, 0, 0, 0, 0, 0, 0, 0}, '{-32768, 0, 0, 0, 0, 0, 0, 0}};
      cs = '{8'h00, 8'h00, 8'h01, 8'h01};
      nm = '{"impulse", "dc", "sat_pos", "sat_neg"};
      out_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         for (int k = 0; k < 8; k++) in_data[k] = 16'(cx[t][k]);
         in_valid = 1'b1;
         #1;
         n_checks++;
         if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_in_ready: got %b want 1", nm[t], in_ready); end
         lat = -1;
         for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (out_valid) lat = c;
         end
         n_checks++;
         if (lat !== 3) begin n_fail++; $display("FAIL %s_latency: got %0d want 3", nm[t], lat); end
         if (lat > 0) begin
            for (int k = 0; k < 8; k++) begin
               n_checks++;
               if (int'(out_data[k]) !== cy[t][k]) begin
                  n_fail++;
                  $display("FAIL %s_X%0d: got %0d want %0d", nm[t], k, out_data[k], cy[t][k]);
               end
            end
            n_checks++;
            if (out_sat !== cs[t]) begin n_fail++; $display("FAIL %s_sat: got %b want %b", nm[t], out_sat, cs[t]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int first = -1, last = -1, got = 0;
      exp_t act;
      logic signed [15:0] v [0:7];
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (c < 12) begin rand_vec(v); in_data = v; in_valid = 1'b1; end
         else in_valid = 1'b0;
         #1;
         if (out_valid) begin
            if (first < 0) first = c;
            last = c;
            n_checks++;
            if (sbq.size() == 0) begin n_fail++; $display("FAIL b2b_extra: got output at cycle %0d want none", c); end
            else begin
               act.sat = out_sat;
               for (int k = 0; k < 8; k++) act.y[k] = int'(out_data[k]);
               if (act !== sbq[0]) begin n_fail++; $display("FAIL b2b_data: got %h want %h", act, sbq[0]); end
               void'(sbq.pop_front());
               got++;
            end
         end
         if (in_valid && in_ready) sbq.push_back(model(in_data, 8, 16));
      end
      n_checks++;
      if (got != 12 || first != 3 || last != 14) begin
         n_fail++;
         $display("FAIL b2b_stream: got count %0d first %0d last %0d want 12 3 14", got, first, last);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      int   sent = 0, got = 0;
      logic [2:0] vm = 3'b000;
      logic en_m;
      logic hold = 1'b0;
      exp_t act;
      logic signed [15:0] v [0:7];
      sbq.delete();
      for (int cyc = 0; cyc < 600 && got < 20; cyc++) begin
         @(negedge clk);
         if (!hold) begin
            if (sent < 20 && $urandom_range(0, 3) != 0) begin rand_vec(v); in_data = v; in_valid = 1'b1; end
            else in_valid = 1'b0;
         end
         out_ready = ($urandom_range(0, 1) == 0);
         #1;
         en_m = !vm[2] || out_ready;
         n_checks++;
         if (in_ready !== en_m) begin n_fail++; $display("FAIL bp_in_ready: cycle %0d got %b want %b", cyc, in_ready, en_m); end
         n_checks++;
         if (out_valid !== vm[2]) begin n_fail++; $display("FAIL bp_out_valid: cycle %0d got %b want %b", cyc, out_valid, vm[2]); end
         if (out_valid) begin
            n_checks++;
            if (sbq.size() == 0) begin n_fail++; $display("FAIL bp_extra: got output at cycle %0d want none", cyc); end
            else begin
               act.sat = out_sat;
               for (int k = 0; k < 8; k++) act.y[k] = int'(out_data[k]);
               if (act !== sbq[0]) begin n_fail++; $display("FAIL bp_data: vec %0d got %h want %h", got, act, sbq[0]); end
               if (out_ready) begin void'(sbq.pop_front()); got++; end
            end
         end
         if (in_valid && in_ready) begin sbq.push_back(model(in_data, 8, 16)); sent++; end
         hold = in_valid && !in_ready;
         if (en_m) vm = {vm[1:0], in_valid};
      end
      n_checks++;
      if (got != 20 || sbq.size() != 0) begin
         n_fail++;
         $display("FAIL bp_count: got %0d outputs, %0d pending want 20, 0", got, sbq.size());
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_midstream();
      logic signed [15:0] v [0:7];
      int   lat = -1;
      logic nz, stale;
      exp_t act, e;
      out_ready = 1'b1;
      sbq.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rand_vec(v); in_data = v; in_valid = 1'b1;
      end
      @(negedge clk);
      rst = 1'b1;
      rand_vec(v); in_data = v; in_valid = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_inflight: got out_valid %b want 1", out_valid); end
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
      n_checks++;
      if (out_sat !== 8'h00) begin n_fail++; $display("FAIL rm_out_sat: got %h want 00", out_sat); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_in_ready: got %b want 1", in_ready); end
      nz = 1'b0;
      for (int k = 0; k < 8; k++) if (out_data[k] !== 16'sd0) nz = 1'b1;
      n_checks++;
      if (nz !== 1'b0) begin n_fail++; $display("FAIL rm_out_data: got nonzero=%b want 0", nz); end
      stale = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         if (out_valid) stale = 1'b1;
      end
      n_checks++;
      if (stale !== 1'b0) begin n_fail++; $display("FAIL rm_stale: got stale output %b want 0", stale); end
      @(negedge clk);
      rand_vec(v); in_data = v; in_valid = 1'b1;
      e = model(v, 8, 16);
      for (int c = 1; c <= 8 && lat < 0; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         if (out_valid) lat = c;
      end
      n_checks++;
      if (lat !== 3) begin n_fail++; $display("FAIL rm_latency: got %0d want 3", lat); end
      if (lat > 0) begin
         act.sat = out_sat;
         for (int k = 0; k < 8; k++) act.y[k] = int'(out_data[k]);
         n_checks++;
         if (act !== e) begin n_fail++; $display("FAIL rm_data: got %h want %h", act, e); end
      end
   endtask

   task automatic test_frac_sweep();
      int   sent = 0;
      int   got [3] = '{0, 0, 0};
      logic done = 1'b0;
      exp_t act;
      logic signed [15:0] v [0:7];
      for (int cyc = 0; cyc < 1500 && !done; cyc++) begin
         @(negedge clk);
         if (sent < 1000 && $urandom_range(0, 9) != 0) begin rand_vec(v); sw_data = v; sw_valid = 1'b1; end
         else sw_valid = 1'b0;
         #1;
         for (int g = 0; g < 3; g++) begin
            if (sw_oval[g]) begin
               n_checks++;
               if (swq[g].size() == 0) begin n_fail++; $display("FAIL sweep%0d_extra: got output want none", g); end
               else begin
                  act.sat = sw_sat[g];
                  for (int k = 0; k < 8; k++) act.y[k] = int'(sw_out[g][k]);
                  if (act !== swq[g][0]) begin
                     n_fail++;
                     $display("FAIL sweep%0d_data: vec %0d got %h want %h", g, got[g], act, swq[g][0]);
                  end
                  void'(swq[g].pop_front());
                  got[g]++;
               end
            end
            if (sw_valid && sw_in_rdy[g])
               swq[g].push_back(model(sw_data, (g == 0) ? 4 : ((g == 1) ? 12 : 16), 20));
         end
         if (sw_valid) sent++;
         done = (sent == 1000) && (got[0] == 1000) && (got[1] == 1000) && (got[2] == 1000);
      end
      for (int g = 0; g < 3; g++) begin
         n_checks++;
         if (got[g] != 1000) begin n_fail++; $display("FAIL sweep%0d_count: got %0d want 1000", g, got[g]); end
      end
      sw_valid = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_data   = '{default: 16'sd0};
      sw_valid  = 1'b0;
      sw_data   = '{default: 16'sd0};
      test_reset();
      test_static_vectors();
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      test_frac_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got time limit reached want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
